// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter paced by an external 16x baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_master,
  input  logic                 rst_i,
  output logic                 tx_o,
  output logic                 tx_done,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 data_we_i,
  input  logic                 tx_en,
  input  logic                 tick
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_nx;

  logic                 tick_q;
  logic                 tick_rise;
  logic                 bit_end;
  logic                 load;
  logic                 done_nx;
  logic [DATA_BITS-1:0] hold;
  logic                 valid;
  logic [DATA_BITS-1:0] shift;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign tick_rise = tick & ~tick_q;
  assign bit_end   = tick_rise &&
                     (tick_cnt == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_master) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done_nx  = 1'b0;
    tx_o     = 1'b1;
    unique case (state)
      IDLE: begin
        if (tx_en && valid) begin
          load     = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx_o = shift[0];
        if (bit_end &&
            bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_o = par;
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Holding-register write is last so a write on the load
  // cycle re-arms valid for the following frame.
  always_ff @(posedge clk_master) begin
    if (!rst_i) begin
      tick_q   <= 1'b0;
      tx_done  <= 1'b0;
      hold     <= '0;
      valid    <= 1'b0;
      shift    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tick_q  <= tick;
      tx_done <= done_nx;
      if (load) begin
        shift    <= hold;
        valid    <= 1'b0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        par      <= ^hold;
`endif
      end else if (tick_rise && state != IDLE) begin
        if (bit_end) tick_cnt <= '0;
        else         tick_cnt <= tick_cnt + 1'b1;
        if (bit_end && state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (data_we_i) begin
        hold  <= data_i;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx
// against a tick-counting frame model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk_master = 1'b0;
  logic       rst_i      = 1'b0;
  logic       tx_o;
  logic       tx_done;
  logic [7:0] data_i     = 8'h00;
  logic       data_we_i  = 1'b0;
  logic       tx_en      = 1'b0;
  logic       tick       = 1'b0;

  int checks = 0;
  int errors = 0;

  int   tick_half = 2;
  int   tcnt      = 0;
  logic tprev     = 1'b0;
  logic rise_now  = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t tbl[8];

  uart_tx dut (
    .clk_master(clk_master),
    .rst_i     (rst_i),
    .tx_o      (tx_o),
    .tx_done   (tx_done),
    .data_i    (data_i),
    .data_we_i (data_we_i),
    .tx_en     (tx_en),
    .tick      (tick)
  );

  always #5 clk_master = ~clk_master;

  // rise_now: the DUT saw a tick rising edge at the last posedge
  initial begin
    forever begin
      @(posedge clk_master);
      rise_now = tick & ~tprev;
      tprev    = tick;
      #1;
      tcnt++;
      if (tcnt >= tick_half) begin
        tcnt = 0;
        tick = ~tick;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    data_i    = b;
    data_we_i = 1'b1;
    @(negedge clk_master);
    data_we_i = 1'b0;
  endtask

  task automatic idle_watch(input int nc,
                            input string nm);
    int lo = 0;
    int dn = 0;
    repeat (nc) begin
      @(negedge clk_master);
      if (tx_o !== 1'b1)    lo++;
      if (tx_done !== 1'b0) dn++;
    end
    chk($sformatf("%s tx_o low cnt", nm), lo, 0);
    chk($sformatf("%s tx_done cnt", nm), dn, 0);
  endtask

  // Expected line level k holds for rises [16k, 16k+16)
  // counted after the edge on which tx_o fell.
  task automatic check_frame(input logic [9:0] fr,
                             input logic par,
                             input bit b2b,
                             input string nm);
    int n = 0;
    int r = 0;
    int lvl = 0;
    int dn = 0;
    int nlev;
    logic got;
    logic [10:0] lv;
`ifdef UART_TX_PARITY_EN
    nlev = 11;
    lv   = {fr[9], par, fr[8:0]};
`else
    nlev = 10;
    lv   = {1'b0, fr};
    if (par === 1'bx) nlev = 10;
`endif
    while (tx_o !== 1'b0 && n < 4000) begin
      @(negedge clk_master);
      n++;
    end
    chk($sformatf("%s start", nm), tx_o, 0);
    if (tx_o !== 1'b0) return;
    n   = 0;
    got = lv[0];
    while (lvl < nlev && n < 2500) begin
      if (tx_done !== 1'b0) dn++;
      if (tx_o !== lv[lvl]) got = tx_o;
      @(negedge clk_master);
      n++;
      if (rise_now) begin
        r++;
        if (r % OS == 0) begin
          chk($sformatf("%s level%0d", nm, lvl),
              got, lv[lvl]);
          lvl++;
          if (lvl < nlev) got = lv[lvl];
        end
      end
    end
    chk($sformatf("%s complete", nm), lvl, nlev);
    if (lvl != nlev) return;
    chk($sformatf("%s early done", nm), dn, 0);
    chk($sformatf("%s tx_done", nm), tx_done, 1);
    chk($sformatf("%s idle line", nm), tx_o, 1);
    @(negedge clk_master);
    chk($sformatf("%s done width", nm), tx_done, 0);
    chk($sformatf("%s after", nm), tx_o, b2b ? 0 : 1);
  endtask

  function automatic logic [9:0] model_frame(
      input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin
    logic [7:0] cur, nxt;
    bit   b2b;
    int   n, r, lo, dn;

    tbl[0] = '{8'hDA, 10'b1110110100, 1'b1};
    tbl[1] = '{8'h2D, 10'b1001011010, 1'b0};
    tbl[2] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[3] = '{8'hA3, 10'b1101000110, 1'b0};
    tbl[4] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[5] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[6] = '{8'h01, 10'b1000000010, 1'b1};
    tbl[7] = '{8'h80, 10'b1100000000, 1'b1};

    // reset held with writes and ticks
    rst_i = 1'b0;
    tx_en = 1'b1;
    lo = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_master);
      if (tx_o !== 1'b1)    lo++;
      if (tx_done !== 1'b0) dn++;
      data_i    = 8'($urandom);
      data_we_i = i[0];
    end
    chk("reset tx_o low cnt", lo, 0);
    chk("reset tx_done cnt", dn, 0);
    data_we_i = 1'b0;
    rst_i = 1'b1;
    idle_watch(300, "post reset");

    // held byte waits for tx_en
    tx_en = 1'b0;
    wr(tbl[0].data);
    idle_watch(100, "en low");
    tx_en = 1'b1;
    check_frame(tbl[0].frame, tbl[0].par, 0, "DA");

    // tx_en dropped mid-frame
    wr(tbl[0].data);
    fork
      check_frame(tbl[0].frame, tbl[0].par, 0,
                  "DA en drop");
      begin
        repeat (300) @(negedge clk_master);
        tx_en = 1'b0;
      end
    join
    wr(tbl[1].data);
    idle_watch(500, "2D en low");
    tx_en = 1'b1;
    check_frame(tbl[1].frame, tbl[1].par, 0, "2D");

    // write during DATA: current frame kept, next b2b
    wr(tbl[2].data);
    fork
      check_frame(tbl[2].frame, tbl[2].par, 1,
                  "55 b2b");
      begin
        repeat (200) @(negedge clk_master);
        wr(tbl[3].data);
      end
    join
    check_frame(tbl[3].frame, tbl[3].par, 0, "A3");

    // mid-frame reset during bit 4, pending byte lost
    wr(8'hFF);
    wr(8'h11);
    n = 0;
    while (tx_o !== 1'b0 && n < 100) begin
      @(negedge clk_master);
      n++;
    end
    chk("rst frame start", tx_o, 0);
    r = 0;
    n = 0;
    while (r < 5 * OS + 8 && n < 1000) begin
      @(negedge clk_master);
      n++;
      if (rise_now) r++;
    end
    chk("rst reach bit4", r, 5 * OS + 8);
    chk("rst bit4 level", tx_o, 1);
    rst_i = 1'b0;
    @(negedge clk_master);
    chk("rst tx_o", tx_o, 1);
    chk("rst tx_done", tx_done, 0);
    repeat (3) @(negedge clk_master);
    rst_i = 1'b1;
    idle_watch(800, "after mid rst");

    // table sweep
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].data);
      check_frame(tbl[i].frame, tbl[i].par, 0,
                  $sformatf("tbl%0d", i));
    end

    // randomized frames, some back to back
    cur = 8'($urandom);
    wr(cur);
    for (int i = 0; i < 12; i++) begin
      nxt = 8'($urandom);
      b2b = ($urandom % 2) == 1;
      if (b2b) begin
        fork
          check_frame(model_frame(cur), ^cur, 1,
                      $sformatf("rnd%0d", i));
          begin
            repeat ($urandom_range(80, 280))
              @(negedge clk_master);
            wr(nxt);
          end
        join
      end else begin
        check_frame(model_frame(cur), ^cur, 0,
                    $sformatf("rnd%0d", i));
        tick_half = $urandom_range(1, 3);
        repeat ($urandom_range(0, 20))
          @(negedge clk_master);
        wr(nxt);
      end
      cur = nxt;
    end
    check_frame(model_frame(cur), ^cur, 0, "rnd last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
